// File: rtl/sd_rx_pkg.sv
// Shared definitions for the multi-lane serial receiver: state encoding,
// CRC16-CCITT constants and the single-bit CRC update used by every lane.
package sd_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_START = 3'd1,
      ST_DATA       = 3'd2,
      ST_CRC        = 3'd3,
      ST_END        = 3'd4,
      ST_DONE       = 3'd5
   } rx_state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam int          CRC_LEN    = 16;

   // One MSB-first step of CRC16-CCITT: shift left, fold the polynomial in
   // when the outgoing bit differs from the incoming data bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic data_bit);
      logic fb;
      fb = crc[15] ^ data_bit;
      crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_lane.sv
// Serial CRC16-CCITT accumulator for one lane. Clear has priority over enable.
module crc16_lane
   import sd_rx_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        data_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   // Next remainder: clear, absorb one data bit, or hold.
   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = 16'h0000;
      end else if (en_i) begin
         crc_d = crc16_step(crc_q, data_i);
      end else begin
         crc_d = crc_q;
      end
   end

   // Remainder register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_q <= 16'h0000;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/serial_to_parallel_multilane.sv
// Framed multi-lane serial receiver: start bit, payload shifted into a
// right-justified parallel register, optional per-lane CRC16, end bit.
// All outputs are driven straight from registers.
module serial_to_parallel_multilane
   import sd_rx_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int LANES  = 1,
   parameter int CNT_W  = 8,
   parameter int CRC_EN = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [LANES-1:0] serial,
   input  logic [CNT_W-1:0] framesize,
   input  logic [15:0]      timeout,
   output logic             busy,
   output logic             complete,
   output logic             crc_error,
   output logic             frame_error,
   output logic             timeout_error,
   output logic [WIDTH-1:0] parallel
);

   localparam logic [CNT_W-1:0] LANES_C  = CNT_W'(LANES);
   localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
   // LANES is a power of two, so rounding down is a mask of the low bits.
   localparam logic [CNT_W-1:0] LEN_MASK = ~(LANES_C - CNT_W'(1));

   rx_state_e              state_q, state_d;
   logic [CNT_W-1:0]       len_q, len_d;
   logic [15:0]            timeout_q, timeout_d;
   logic [15:0]            wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [4:0]             crc_cnt_q, crc_cnt_d;
   logic [LANES-1:0][15:0] rx_crc_q, rx_crc_d;
   logic [WIDTH-1:0]       par_q, par_d;
   logic                   busy_q, busy_d;
   logic                   complete_q, complete_d;
   logic                   crc_err_q, crc_err_d;
   logic                   frame_err_q, frame_err_d;
   logic                   timeout_err_q, timeout_err_d;

   logic [CNT_W-1:0]       eff_len_s;
   logic                   bad_size_s;
   logic                   data_last_s;
   logic                   crc_mismatch_s;
   logic                   crc_clr_s;
   logic                   crc_en_s;
   logic [LANES-1:0][15:0] crc_calc_s;

   assign eff_len_s   = framesize & LEN_MASK;
   assign bad_size_s  = (eff_len_s == '0) || (framesize > WIDTH_C);
   assign data_last_s = ({1'b0, bit_cnt_q} + {1'b0, LANES_C}) >= {1'b0, len_q};
   // Lane CRCs restart while idle and only absorb payload bits.
   assign crc_clr_s   = (state_q == ST_IDLE);
   assign crc_en_s    = (state_q == ST_DATA);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      crc16_lane u_crc (
         .clk_i  (Clock),
         .rst_ni (Reset),
         .clr_i  (crc_clr_s),
         .en_i   (crc_en_s),
         .data_i (serial[g]),
         .crc_o  (crc_calc_s[g])
      );
   end

   // Compare every lane's received CRC (last bit still on the wire) with its computed one.
   always_comb begin
      crc_mismatch_s = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         crc_mismatch_s = crc_mismatch_s |
                          ({rx_crc_q[l][14:0], serial[l]} != crc_calc_s[l]);
      end
   end

   // Next-state, counters, data path and flag updates.
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      timeout_d     = timeout_q;
      wait_cnt_d    = wait_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      crc_cnt_d     = crc_cnt_q;
      rx_crc_d      = rx_crc_q;
      par_d         = par_q;
      crc_err_d     = crc_err_q;
      frame_err_d   = frame_err_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         ST_IDLE: begin
            if (Enable) begin
               len_d         = eff_len_s;
               timeout_d     = timeout;
               wait_cnt_d    = 16'd0;
               bit_cnt_d     = '0;
               crc_cnt_d     = 5'd0;
               par_d         = '0;
               crc_err_d     = 1'b0;
               frame_err_d   = 1'b0;
               timeout_err_d = 1'b0;
               if (bad_size_s) begin
                  frame_err_d = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_WAIT_START;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_START: begin
            if (!Enable) begin
               state_d = ST_IDLE;
            end else if (serial == '0) begin
               state_d = ST_DATA;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
               if ((timeout_q != 16'd0) && (wait_cnt_d == timeout_q)) begin
                  timeout_err_d = 1'b1;
                  state_d       = ST_DONE;
               end else begin
                  state_d = ST_WAIT_START;
               end
            end
         end
         ST_DATA: begin
            if (!Enable) begin
               state_d = ST_IDLE;
            end else begin
               par_d     = {par_q[WIDTH-LANES-1:0], serial};
               bit_cnt_d = bit_cnt_q + LANES_C;
               if (data_last_s) begin
                  state_d = (CRC_EN != 0) ? ST_CRC : ST_END;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_CRC: begin
            if (!Enable) begin
               state_d = ST_IDLE;
            end else begin
               for (int l = 0; l < LANES; l++) begin
                  rx_crc_d[l] = {rx_crc_q[l][14:0], serial[l]};
               end
               crc_cnt_d = crc_cnt_q + 5'd1;
               if (crc_cnt_q == 5'(CRC_LEN - 1)) begin
                  crc_err_d = crc_mismatch_s;
                  state_d   = ST_END;
               end else begin
                  state_d = ST_CRC;
               end
            end
         end
         ST_END: begin
            if (!Enable) begin
               state_d = ST_IDLE;
            end else begin
               if (serial != '1) begin
                  frame_err_d = 1'b1;
               end else begin
                  frame_err_d = frame_err_q;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // DONE is always a single-cycle state, so entering it is the pulse.
      busy_d     = (state_d != ST_IDLE);
      complete_d = (state_d == ST_DONE);
   end

   // State, counters and output registers.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q       <= ST_IDLE;
         len_q         <= '0;
         timeout_q     <= 16'd0;
         wait_cnt_q    <= 16'd0;
         bit_cnt_q     <= '0;
         crc_cnt_q     <= 5'd0;
         rx_crc_q      <= '0;
         par_q         <= '0;
         busy_q        <= 1'b0;
         complete_q    <= 1'b0;
         crc_err_q     <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         timeout_q     <= timeout_d;
         wait_cnt_q    <= wait_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         crc_cnt_q     <= crc_cnt_d;
         rx_crc_q      <= rx_crc_d;
         par_q         <= par_d;
         busy_q        <= busy_d;
         complete_q    <= complete_d;
         crc_err_q     <= crc_err_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign busy          = busy_q;
   assign complete      = complete_q;
   assign crc_error     = crc_err_q;
   assign frame_error   = frame_err_q;
   assign timeout_error = timeout_err_q;
   assign parallel      = par_q;

endmodule

// File: tb/tb_serial_to_parallel_multilane.sv
// Bench for serial_to_parallel_multilane: one single-lane no-CRC instance and
// one four-lane CRC instance, driven by directed and random frames. Expected
// outputs come from a frame-level model built from the framing rules.
module tb_serial_to_parallel_multilane;

   logic        Clock;
   logic        Reset;
   logic        en0, en1;
   logic        ser0;
   logic [3:0]  ser1;
   logic [7:0]  fs0, fs1;
   logic [15:0] to0, to1;
   logic        busy0, busy1, cmp0, cmp1, ce0, ce1, fe0, fe1, te0, te1;
   logic [63:0] par0, par1;

   int checks = 0;
   int errors = 0;

   bit          exp_busy  [2];
   bit          exp_cmp   [2];
   bit          exp_valid [2];
   bit          exp_ce    [2];
   bit          exp_fe    [2];
   bit          exp_te    [2];
   logic [63:0] exp_par   [2];

   serial_to_parallel_multilane #(.WIDTH(64), .LANES(1), .CNT_W(8), .CRC_EN(0)) u_dut1 (
      .Clock(Clock), .Reset(Reset), .Enable(en0), .serial(ser0),
      .framesize(fs0), .timeout(to0), .busy(busy0), .complete(cmp0),
      .crc_error(ce0), .frame_error(fe0), .timeout_error(te0), .parallel(par0)
   );

   serial_to_parallel_multilane #(.WIDTH(64), .LANES(4), .CNT_W(8), .CRC_EN(1)) u_dut4 (
      .Clock(Clock), .Reset(Reset), .Enable(en1), .serial(ser1),
      .framesize(fs1), .timeout(to1), .busy(busy1), .complete(cmp1),
      .crc_error(ce1), .frame_error(fe1), .timeout_error(te1), .parallel(par1)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference CRC16-CCITT step (poly 0x1021, MSB first).
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   function automatic logic [15:0] crc_check_string();
      logic [15:0] c;
      logic [7:0]  v;
      c = 16'h0000;
      for (int i = 0; i < 9; i++) begin
         v = 8'h31 + 8'(i);
         for (int b = 7; b >= 0; b--) c = crc_step(c, v[b]);
      end
      return c;
   endfunction

   task automatic cmp_dut(input int d, input logic b, input logic c, input logic ce,
                          input logic fe, input logic te, input logic [63:0] p);
      check($sformatf("busy%0d", d), {63'd0, b}, {63'd0, exp_busy[d]});
      check($sformatf("complete%0d", d), {63'd0, c}, {63'd0, exp_cmp[d]});
      if (exp_valid[d]) begin
         check($sformatf("parallel%0d", d), p, exp_par[d]);
         check($sformatf("crc_error%0d", d), {63'd0, ce}, {63'd0, exp_ce[d]});
         check($sformatf("frame_error%0d", d), {63'd0, fe}, {63'd0, exp_fe[d]});
         check($sformatf("timeout_error%0d", d), {63'd0, te}, {63'd0, exp_te[d]});
      end
   endtask

   // Per-cycle comparison of both instances against the model, away from the active edge.
   always @(negedge Clock) begin
      cmp_dut(0, busy0, cmp0, ce0, fe0, te0, par0);
      cmp_dut(1, busy1, cmp1, ce1, fe1, te1, par1);
   end

   task automatic drive(input int d, input logic en, input logic [3:0] s);
      if (d == 0) begin
         en0 = en; ser0 = s[0];
      end else begin
         en1 = en; ser1 = s;
      end
   endtask

   task automatic apply_reset();
      @(posedge Clock); #1;
      Reset = 1'b0;
      en0 = 1'b0; en1 = 1'b0; ser0 = 1'b1; ser1 = 4'hF;
      for (int d = 0; d < 2; d++) begin
         exp_busy[d] = 0; exp_cmp[d] = 0; exp_valid[d] = 1;
         exp_ce[d] = 0; exp_fe[d] = 0; exp_te[d] = 0; exp_par[d] = 64'd0;
      end
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b1;
   endtask

   // Runs one frame on instance d (0: 1 lane no CRC, 1: 4 lanes with CRC).
   // Called and returns 1 time unit after a rising edge; the next edge is E0.
   task automatic run_frame(input int d, input int fsz, input int tmo, input int wait_cyc,
                            input logic [63:0] data, input logic [3:0] bad, input bit end_ok,
                            input int abort_sel, input bit keep_en, output int len);
      int          lanes, eff, nd, abort_at, idx;
      bit          illegal;
      logic [3:0]  stim[$];
      logic [3:0]  g;
      logic [15:0] crcs[4];
      logic [63:0] rpar;
      bit          rce, rfe, rte;

      lanes   = (d == 1) ? 4 : 1;
      eff     = (fsz / lanes) * lanes;
      nd      = eff / lanes;
      illegal = (eff == 0) || (fsz > 64);
      rpar = 64'd0; rce = 0; rfe = 0; rte = 0;
      if (illegal) begin
         rfe = 1;
      end else if (tmo != 0 && wait_cyc >= tmo) begin
         repeat (tmo) stim.push_back(4'hF);
         rte = 1;
      end else begin
         repeat (wait_cyc) stim.push_back(4'hF);
         stim.push_back(4'h0);
         for (int j = 0; j < nd; j++) begin
            g = 4'h0;
            for (int l = 0; l < lanes; l++) g[l] = data[eff - j*lanes - lanes + l];
            stim.push_back(g);
         end
         rpar = data & ((64'd1 << eff) - 64'd1);
         if (d == 1) begin
            for (int l = 0; l < 4; l++) begin
               crcs[l] = 16'h0000;
               for (int j = 0; j < nd; j++) crcs[l] = crc_step(crcs[l], data[eff - j*4 - 4 + l]);
            end
            for (int k = 0; k < 16; k++) begin
               for (int l = 0; l < 4; l++) g[l] = crcs[l][15-k] ^ (bad[l] && k == 15);
               stim.push_back(g);
            end
            rce = (bad != 4'h0);
         end
         stim.push_back(end_ok ? 4'hF : 4'hE);
         rfe = !end_ok;
      end
      len      = stim.size();
      abort_at = (abort_sel > 0 && len > 0) ? 1 + (abort_sel % len) : -1;

      if (d == 0) begin fs0 = 8'(fsz); to0 = 16'(tmo); end
      else        begin fs1 = 8'(fsz); to1 = 16'(tmo); end
      drive(d, 1'b1, 4'hF);
      @(posedge Clock); #1;                       // E0
      exp_valid[d] = 0;
      exp_busy[d]  = 1;
      exp_cmp[d]   = 0;
      for (int k = 1; k <= len; k++) begin
         idx = k - 1;
         drive(d, (k == abort_at) ? 1'b0 : 1'b1, stim[idx]);
         @(posedge Clock); #1;                    // E_k
         if (k == abort_at) begin
            exp_busy[d] = 0;
            drive(d, 1'b0, 4'hF);
            return;
         end
      end
      exp_cmp[d] = 1; exp_valid[d] = 1;
      exp_par[d] = rpar; exp_ce[d] = rce; exp_fe[d] = rfe; exp_te[d] = rte;
      drive(d, keep_en, 4'hF);
      @(posedge Clock); #1;
      exp_busy[d] = 0; exp_cmp[d] = 0;
   endtask

   initial begin
      int len, d_cur, d_next, fsz, tmo, wt, pick, abort_sel;
      logic [63:0] data;
      logic [3:0]  bad;
      bit          keep, end_ok;

      Reset = 1'b0;
      en0 = 1'b0; en1 = 1'b0; ser0 = 1'b1; ser1 = 4'hF;
      fs0 = 8'd0; fs1 = 8'd0; to0 = 16'd0; to1 = 16'd0;
      for (int d = 0; d < 2; d++) begin
         exp_busy[d] = 0; exp_cmp[d] = 0; exp_valid[d] = 1;
         exp_ce[d] = 0; exp_fe[d] = 0; exp_te[d] = 0; exp_par[d] = 64'd0;
      end
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b1;

      // Model pin: standard CRC16 check value for "123456789".
      check("crc_model_check", {48'd0, crc_check_string()}, 64'h31C3);

      // Single lane, 64 bits, no CRC.
      run_frame(0, 64, 0, 0, 64'hF0F0F0F0F0F0F0F0, 4'h0, 1, 0, 0, len);
      check("len_lane1_64", 64'(len), 64'd66);
      check("par_lane1_64", par0, 64'hF0F0F0F0F0F0F0F0);
      check("fe_lane1_64", {63'd0, fe0}, 64'd0);

      // Four lanes, 32 bits of zeros, zero CRCs.
      run_frame(1, 32, 0, 0, 64'd0, 4'h0, 1, 0, 0, len);
      check("len_lane4_32", 64'(len), 64'd26);
      check("ce_lane4_good", {63'd0, ce1}, 64'd0);

      // Lane 2 sends CRC 0x0001.
      run_frame(1, 32, 0, 0, 64'd0, 4'b0100, 1, 0, 0, len);
      check("ce_lane4_bad", {63'd0, ce1}, 64'd1);
      check("fe_lane4_bad", {63'd0, fe1}, 64'd0);

      // Byte frame with a bad end bit.
      run_frame(0, 8, 0, 2, 64'h00000000000000A5, 4'h0, 0, 0, 0, len);
      check("par_a5", par0, 64'h00000000000000A5);
      check("fe_a5", {63'd0, fe0}, 64'd1);

      // Timeout of 10 with lanes held high.
      run_frame(0, 16, 10, 30, 64'd0, 4'h0, 1, 0, 0, len);
      check("len_timeout", 64'(len), 64'd10);
      check("te_timeout", {63'd0, te0}, 64'd1);

      // Abort in DATA, reset, then a clean frame.
      run_frame(0, 64, 0, 0, 64'h123456789ABCDEF0, 4'h0, 1, 9, 0, len);
      repeat (2) @(posedge Clock);
      #1;
      apply_reset();
      run_frame(0, 64, 0, 1, 64'hDEADBEEFCAFEF00D, 4'h0, 1, 0, 0, len);
      check("par_after_reset", par0, 64'hDEADBEEFCAFEF00D);

      // Randomized frames on both instances, including back-to-back ones.
      d_next = $urandom_range(0, 1);
      for (int n = 0; n < 40; n++) begin
         d_cur  = d_next;
         d_next = $urandom_range(0, 1);
         keep   = (n < 39) && (d_next == d_cur) && ($urandom_range(0, 1) == 1);
         pick   = $urandom_range(0, 9);
         if (pick == 0)      fsz = $urandom_range(0, 3);
         else if (pick == 1) fsz = $urandom_range(65, 80);
         else                fsz = $urandom_range(1, 64);
         wt   = $urandom_range(0, 4);
         pick = $urandom_range(0, 3);
         if (pick == 0)      tmo = 0;
         else if (pick == 1) tmo = $urandom_range(1, 3);
         else                tmo = wt + $urandom_range(1, 4);
         data      = {$urandom, $urandom};
         bad       = (d_cur == 1 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         end_ok    = ($urandom_range(0, 3) != 0);
         abort_sel = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 200) : 0;
         run_frame(d_cur, fsz, tmo, wt, data, bad, end_ok, abort_sel, keep, len);
         if (!keep) begin
            repeat ($urandom_range(0, 2)) @(posedge Clock);
            #1;
         end
      end
      repeat (3) @(posedge Clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_to_parallel_multilane.md
# serial_to_parallel_multilane

Parametrised successor to the single-lane serial-to-parallel wrapper. Receives one framed data block on 1, 4 or 8 serial lanes, each framed as start bit, data, optional per-lane CRC16 and end bit. Presents the block right-justified on a parallel bus, with completion and error flags. Sits behind the input PADs on the card-side data path and feeds the host data buffer.

## Interface
- `WIDTH`, 64: maximum frame payload in bits; width of `parallel`.
- `LANES`, 1: number of serial lanes; legal values are 1, 4 and 8.
- `CNT_W`, 8: width of `framesize`; must hold `WIDTH`.
- `CRC_EN`, 1: 1 means each lane carries a 16-bit CRC after the data; 0 means no CRC phase.
- `Clock` in, 1: single clock; all lanes are sampled on its rising edge.
- `Reset` in, 1: asynchronous, active-low reset.
- `Enable` in, 1: level. High arms or continues reception; low aborts.
- `serial` in, LANES: serial lanes. Lane LANES-1 carries the most significant bit of each LANES-bit group.
- `framesize` in, CNT_W: total payload bits. Latched on leaving IDLE.
- `timeout` in, 16: maximum number of cycles to wait for the start bit. Latched on leaving IDLE.
- `busy` out, 1: high in every state except IDLE.
- `complete` out, 1: one-cycle pulse when a frame ends, whether good or bad.
- `crc_error` out, 1: received CRC mismatched on at least one lane.
- `frame_error` out, 1: bad end bit, or illegal `framesize`.
- `timeout_error` out, 1: no start bit arrived within `timeout` cycles.
- `parallel` out, WIDTH: received payload, right-justified.

## Operation
- **State machine:** IDLE, WAIT_START, DATA, CRC, END, DONE.
- **IDLE:**
  - On `Enable`=1, latch `framesize` and `timeout`, clear all error flags and `parallel`, then go to WAIT_START.
  - Effective frame length is `framesize` rounded down to a multiple of LANES.
  - If the effective length is 0, or `framesize` > WIDTH, set `frame_error` and go straight to DONE.
- **WAIT_START:**
  - All lanes sampled 0 means start bit; go to DATA.
  - Otherwise increment the wait counter. When it reaches `timeout`, set `timeout_error` and go to DONE.
  - `timeout`=0 means wait forever.
- **DATA:**
  - Each cycle, shift `serial` into the low LANES bits of `parallel`; the earlier bits move up.
  - After framesize/LANES cycles, go to CRC if CRC_EN=1, else go to END.
  - The first bit received ends at `parallel[framesize-1]`. Bits at framesize and above stay 0.
- **CRC:**
  - Runs for 16 cycles; each lane supplies its CRC MSB first.
  - Per-lane CRC16-CCITT (polynomial 0x1021, init 0x0000) covers only that lane's data bits.
  - Any mismatch sets `crc_error`. Then go to END.
- **END:** All lanes must be 1; otherwise set `frame_error`. Go to DONE.
- **DONE:** Pulse `complete` for one cycle, then go to IDLE. `parallel` and the error flags hold until the next exit from IDLE.
- **Abort:** `Enable`=0 in WAIT_START, DATA, CRC or END returns to IDLE on the next edge. No `complete` pulse; `parallel` is left partial; error flags are unchanged.
- **Back-to-back frames:** `Enable` held high after DONE re-arms immediately. IDLE lasts one cycle between frames.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `parallel`; all counters 0.
- **Data start:** the start bit is sampled at edge S. The first data group is sampled at S+1.
- **Data end:** the last data group is sampled at S+N, where N = framesize/LANES.
- **CRC:** CRC bits are sampled at S+N+1 through S+N+16.
- **End bit:** sampled at S+N+17 when CRC_EN=1, or at S+N+1 when CRC_EN=0.
- **`complete`:** high during the cycle after the end-bit edge. `parallel` and all flags are valid in that same cycle.
- **Timeout:** `timeout_error` and `complete` assert together, `timeout`+1 cycles after entering WAIT_START.
- **Register outputs:** all outputs come straight from registers, with no combinational path from `serial`.

## Structure
- Shared package `sd_rx_pkg` holds:
  - state encodings;
  - `CRC16_POLY` = 16'h1021;
  - `CRC_LEN` = 16.
- One sub-module, `crc16_lane`: a serial CRC16 with clear, enable and data-bit inputs and a 16-bit remainder output. It is instantiated LANES times by generate.
- Counters live in the top module: wait counter 16 bits, bit counter CNT_W bits, CRC counter 5 bits.

## Test plan
- LANES=1, CRC_EN=0, framesize=64, payload 64'hF0F0F0F0F0F0F0F0 MSB first after a 0 start bit, end bit 1 -> `complete` at S+66, `parallel`=64'hF0F0F0F0F0F0F0F0, no errors.
- LANES=4, CRC_EN=1, framesize=32, all-zero data, each lane CRC 16'h0000, end 4'hF -> `complete` at S+26, `parallel`=0, `crc_error`=0.
- Same as previous, but lane 2 sends CRC 16'h0001 -> `crc_error`=1, `frame_error`=0, `complete` pulses.
- LANES=1, framesize=8, data 8'hA5, end bit 0 -> `parallel`=64'h00000000000000A5, `frame_error`=1.
- `timeout`=10, lanes held high -> `timeout_error`=1 and `complete` 11 cycles after WAIT_START entry; `busy` falls next cycle.
- `Enable` dropped midway through DATA, then `Reset` pulsed low for 3 cycles -> no `complete`; after reset all outputs 0 and state IDLE; the next full frame is received correctly.
